// File: rtl/mux_operand_sequencer_pkg.sv
// mux_seq_pkg: shared state encoding, lane width and count clamp for the operand mux path
package mux_seq_pkg;

    typedef enum logic {IDLE, ISSUE} state_e;

    localparam int LANE_WIDTH = 16;

    function automatic int clamp_count(int count, int num_inputs);
        return (count > num_inputs) ? num_inputs : count;
    endfunction

endpackage

// File: rtl/mux_operand_sequencer_if.sv
// mux_operand_sequencer_if: upstream vector handshake plus downstream lane handshake
interface mux_operand_sequencer_if
    import mux_seq_pkg::*;
#(
    parameter int BIT_WIDTH = LANE_WIDTH,
    parameter int SEL_WIDTH = 1
);
    localparam int NUM_INPUTS = 1 << SEL_WIDTH;

    logic                            i_valid;
    logic                            o_ready;
    logic [NUM_INPUTS*BIT_WIDTH-1:0] i_inputs;
    logic [SEL_WIDTH:0]              i_count;
    logic                            o_valid;
    logic                            i_ready;
    logic [SEL_WIDTH-1:0]            o_sel;
    logic [NUM_INPUTS*BIT_WIDTH-1:0] o_inputs;
    logic                            o_last;

    modport slave (
        input  i_valid, i_inputs, i_count, i_ready,
        output o_ready, o_valid, o_sel, o_inputs, o_last
    );

    modport master (
        output i_valid, i_inputs, i_count, i_ready,
        input  o_ready, o_valid, o_sel, o_inputs, o_last
    );

endinterface

// File: rtl/mux_operand_sequencer.sv
// mux_operand_sequencer: holds one operand vector and walks the mux select over its active lanes
module mux_operand_sequencer
    import mux_seq_pkg::*;
#(
    parameter int BIT_WIDTH = LANE_WIDTH,
    parameter int SEL_WIDTH = 1
)
(
    input  logic clk,
    input  logic rst_n,
    mux_operand_sequencer_if.slave bus
);

    localparam int NUM_INPUTS = 1 << SEL_WIDTH;
    localparam int CW         = SEL_WIDTH + 1;
    localparam int DW         = NUM_INPUTS * BIT_WIDTH;

    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        data_q, data_d;
    logic [CW-1:0]        eff_cnt;
    logic                 valid, last, done, accept;

    assign valid   = (state_q == ISSUE);
    assign last    = valid && ({1'b0, sel_q} == cnt_q - CW'(1));
    assign done    = valid && bus.i_ready && last;
    assign eff_cnt = CW'(clamp_count(int'(bus.i_count), NUM_INPUTS));
    assign accept  = bus.i_valid && bus.o_ready;

    assign bus.o_ready  = rst_n && (state_q == IDLE || done);
    assign bus.o_valid  = valid;
    assign bus.o_last   = last;
    assign bus.o_sel    = sel_q;
    assign bus.o_inputs = data_q;

    // Next state: advance lane on handshake, retire on last lane, load on a non-empty accept
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (valid && bus.i_ready && !last) sel_d = sel_q + SEL_WIDTH'(1);
        if (done) state_d = IDLE;
        if (accept && eff_cnt != '0) begin
            state_d = ISSUE;
            sel_d   = '0;
            cnt_d   = eff_cnt;
            data_d  = bus.i_inputs;
        end
    end

    // State, select counter and holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_mux_operand_sequencer.sv
// tb_mux_operand_sequencer: scoreboard bench for lane sequencing, backpressure, boundary counts and reset
module tb_mux_operand_sequencer;

    typedef struct {
        logic [1:0]  sel;
        logic [63:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int fails = 0;
    exp_t q[$];

    mux_operand_sequencer_if #(.BIT_WIDTH(16), .SEL_WIDTH(2)) bus ();

    mux_operand_sequencer #(.BIT_WIDTH(16), .SEL_WIDTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [2:0] c);
        int n = 0;
        int eff;
        bus.i_inputs = d;
        bus.i_count  = c;
        bus.i_valid  = 1'b1;
        @(negedge clk);
        while (!bus.o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) chk("accept_timeout", 64'(bus.o_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_inputs = ~d;
        bus.i_count  = 3'd5;
        eff = (c > 3'd4) ? 4 : int'(c);
        for (int k = 0; k < eff; k++) q.push_back('{2'(k), d, k == eff - 1});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_lane", 64'(bus.o_valid), 64'd0);
                end else begin
                    chk("sel", 64'(bus.o_sel), 64'(q[0].sel));
                    chk("inputs", bus.o_inputs, q[0].data);
                    chk("last", 64'(bus.o_last), 64'(q[0].last));
                    chk("ready_last_term", 64'(bus.o_ready), 64'(bus.i_ready & q[0].last));
                    if (bus.i_ready) void'(q.pop_front());
                end
            end else if (q.size() != 0) begin
                chk("bubble_valid", 64'(bus.o_valid), 64'd1);
            end
        end
    end

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_ready  = 1'b0;
        bus.i_inputs = '0;
        bus.i_count  = '0;
        #3;
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_last", 64'(bus.o_last), 64'd0);
        chk("rst_sel", 64'(bus.o_sel), 64'd0);
        chk("rst_inputs", bus.o_inputs, 64'd0);
        chk("rst_ready", 64'(bus.o_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 64'(bus.o_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        send(64'h4444_3333_2222_1111, 3'd4);
        drain();
        send(64'hAAAA_BBBB_CCCC_DDDD, 3'd3);
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        drain();
        send(64'h0102_0304_0506_0708, 3'd2);
        send(64'h1111_2222_3333_4444, 3'd3);
        drain();
        send(64'hFFFF_EEEE_DDDD_CCCC, 3'd0);
        repeat (4) begin
            @(negedge clk);
            chk("cnt0_valid", 64'(bus.o_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(64'h9999_8888_7777_6666, 3'd7);
        drain();
        send(64'h5555_6666_7777_8888, 3'd1);
        drain();
        send(64'hBEEF_CAFE_F00D_D00D, 3'd4);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_sel", 64'(bus.o_sel), 64'd2);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_valid", 64'(bus.o_valid), 64'd0);
        chk("midrst_sel", 64'(bus.o_sel), 64'd0);
        chk("midrst_last", 64'(bus.o_last), 64'd0);
        chk("midrst_inputs", bus.o_inputs, 64'd0);
        chk("midrst_ready", 64'(bus.o_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("post_rst_valid", 64'(bus.o_valid), 64'd0);
            chk("post_rst_ready", 64'(bus.o_ready), 64'd1);
        end
        chk("final_queue", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mux_operand_sequencer.md
# mux_operand_sequencer

- **Function:** Upstream feeder for the registered N:1 operand mux stage.
- **Input side:** Accepts one packed vector of `NUM_INPUTS` operands per valid/ready handshake and holds it.
- **Output side:** Steps the mux select through the vector's active lanes, one lane per downstream handshake.
- **Purpose:** Serializes a wide operand bundle into the mux datapath without dropping or repeating lanes under backpressure.

## Interface
- `BIT_WIDTH`, 16, operand width.
- `SEL_WIDTH`, 1, select width.
- `NUM_INPUTS`, `1 << SEL_WIDTH`, lanes per vector.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_valid`  in  1  upstream vector valid.
- `o_ready`  out  1  block can accept a vector this cycle.
- `i_inputs`  in  `NUM_INPUTS*BIT_WIDTH`  packed vector; lane k at `[(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH]`.
- `i_count`  in  `SEL_WIDTH+1`  active lanes, 0..`NUM_INPUTS`.
- `o_valid`  out  1  `o_sel`/`o_inputs` present a lane.
- `i_ready`  in  1  downstream mux stage consumes the lane.
- `o_sel`  out  `SEL_WIDTH`  mux select, i.e. current lane index.
- `o_inputs`  out  `NUM_INPUTS*BIT_WIDTH`  held vector driven to the mux data inputs.
- `o_last`  out  1  current lane is the vector's final active lane.

## Operation
- **FSM states:**
  - `IDLE`: no vector held.
  - `ISSUE`: vector held, lanes being presented.
- **`o_ready`:**
  - Combinational.
  - Equal to `rst_n & (state==IDLE | (o_valid & i_ready & o_last))`.
- **Accept condition:** `i_valid & o_ready`. On accept:
  - Latch `i_inputs` into the holding register.
  - Latch the effective count.
  - Set `o_sel`=0.
  - Enter `ISSUE`.
- **Effective count:**
  - `i_count` > `NUM_INPUTS` is clamped to `NUM_INPUTS`.
  - `i_count`=0 is accepted and discarded: no lane is issued, state stays/returns `IDLE`, holding register unchanged.
- **`ISSUE` state:**
  - `o_valid`=1.
  - `o_last` = (`o_sel` == count-1).
- **Downstream handshake** (`o_valid & i_ready`):
  - Not `o_last`: `o_sel` increments by 1.
  - `o_last` with no simultaneous accept: return to `IDLE`, `o_valid`=0.
  - `o_last` with a simultaneous accept: load the new vector, `o_sel`=0, stay in `ISSUE`. This is back-to-back, with zero bubble.
- **Stability:** While `o_valid & !i_ready`, `o_sel`, `o_inputs` and `o_last` are held stable.
- **`o_sel` range:** never exceeds count-1, never wraps past it.
- **`IDLE` state:**
  - `o_valid`=0 and `o_last`=0.
  - `o_sel` and `o_inputs` hold their last values, which are don't-care.

## Timing
- **Reset values** (`rst_n` low, immediate):
  - state=`IDLE`.
  - `o_valid`=0, `o_last`=0, `o_sel`=0, `o_inputs`=0.
  - `o_ready`=0 while `rst_n` low, and 1 from the first cycle after release.
- **Latency:** vector accepted at edge N → lane 0 valid in cycle N+1.
- **Throughput:** a count-c vector with `i_ready` held high occupies exactly c cycles. Sustained throughput is 1 lane/cycle across vectors.
- **No combinational paths** from `i_valid` or `i_inputs` to any output.
- **Combinational `i_ready`→`o_ready` path:** exists only through the last-lane term.
- **Reset mid-vector:** the vector is dropped with no further lanes, and all outputs take their reset values asynchronously.

## Structure
- **Package `mux_seq_pkg`:**
  - State enum {`IDLE`, `ISSUE`}.
  - Lane-slice width constant and count clamp helper, both shared with the mux top-level.
- **No sub-module:** a single FSM plus holding register and select counter. The select counter is inline.

## Test plan
Benches use `BIT_WIDTH`=16, `SEL_WIDTH`=2.
- **Full vector, `i_ready`=1:** vector {0x4444,0x3333,0x2222,0x1111}, count 4.
  - `o_valid` for 4 cycles.
  - `o_sel` 0,1,2,3.
  - `o_last` only on sel 3.
  - `o_ready`=1 on the sel-3 cycle.
- **Backpressure:** count 3, `i_ready` low 2 cycles at sel 1 → `o_sel` stays 1, `o_inputs` stable, then 2 with `o_last`=1.
- **Back-to-back:** second vector valid during the first vector's last-lane handshake.
  - Accepted that cycle.
  - Next cycle `o_sel`=0 of the new vector, no bubble.
- **Boundary counts:**
  - count 0 → accepted, `o_valid` never rises.
  - count 7 → clamped, exactly 4 lanes.
  - count 1 → `o_last`=1 with sel 0.
- **Reset:** `rst_n` low mid-vector at sel 2 → `o_valid`=0 and `o_sel`=0 immediately; after release `o_ready`=1 and no stale lane appears.
